// File: rtl/rf_wb_scoreboard_if.sv
// Writeback / scoreboard bus for the register-file writeback controller.
// Bundles the decode issue port, the ALU and MEM writeback sources, and the
// registered register-file write port plus scoreboard status.
//   master : decode + writeback sources + register file (drives issue/alu/mem,
//            observes stall, readys, write port, busy, err)
//   slave  : rf_wb_scoreboard
interface rf_wb_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            stall;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;

    logic            we_reg;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] d;
    logic [NREG-1:0] busy;
    logic            err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  stall, alu_ready, mem_ready,
        input  we_reg, rd, d, busy, err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output stall, alu_ready, mem_ready,
        output we_reg, rd, d, busy, err
    );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Writeback controller for a 32x32 register file with x0 hardwired to zero.
// Arbitrates the single write port between the ALU and MEM writeback sources,
// registers the write (we_reg/rd/d, latency 1) and keeps a per-register busy
// scoreboard that decode uses to stall RAW/WAW hazards (no bypass network).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - rf_wb_scoreboard_if.slave: issue_valid/rs1/rs2/rd -> stall,
//          alu_valid/rd/data -> alu_ready, mem_valid/rd/data -> mem_ready,
//          we_reg/rd/d write port, busy scoreboard vector, sticky err
module rf_wb_scoreboard #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int STARVE_MAX = 3
) (
    input logic               clk,
    input logic               rst,
    rf_wb_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + SW'(1);
    endfunction

    logic [SW-1:0]   starve_cnt;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic            err_q;

    logic            contested;
    logic            grant_alu;
    logic            grant_mem;
    logic            hz;
    logic            stall_c;
    logic            accept;

    logic            xfer_p0;
    logic [AW-1:0]   x_rd_p0;
    logic [XLEN-1:0] x_data_p0;

    logic            vld_p1;
    logic [AW-1:0]   rd_p1;
    logic [XLEN-1:0] d_p1;

    // ---- stage p0: arbitration and hazard detection (combinational) ----
    always_comb begin
        contested = bus.alu_valid && bus.mem_valid;
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!rst) begin
            if (contested) begin
                // MEM normally wins; after STARVE_MAX straight losses ALU gets one turn
                if (starve_cnt == STARVE_LIM) grant_alu = 1'b1;
                else                          grant_mem = 1'b1;
            end else begin
                grant_alu = bus.alu_valid;
                grant_mem = bus.mem_valid;
            end
        end

        xfer_p0   = grant_alu || grant_mem;
        x_rd_p0   = grant_alu ? bus.alu_rd   : bus.mem_rd;
        x_data_p0 = grant_alu ? bus.alu_data : bus.mem_data;

        hz = ((bus.issue_rs1 != '0) && busy_q[bus.issue_rs1]) ||
             ((bus.issue_rs2 != '0) && busy_q[bus.issue_rs2]) ||
             ((bus.issue_rd  != '0) && busy_q[bus.issue_rd]);
        stall_c = !rst && bus.issue_valid && hz;
        accept  = !rst && bus.issue_valid && !hz;

        busy_nxt = busy_q;
        if (accept && (bus.issue_rd != '0)) busy_nxt[bus.issue_rd] = 1'b1;
        // clear after set: a same-index collision resolves to clear
        if (vld_p1) busy_nxt[rd_p1] = 1'b0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (contested && grant_mem) starve_cnt <= sat_inc(starve_cnt);
            else                        starve_cnt <= '0;
            busy_q <= busy_nxt;
            // writeback to a register nobody was waiting on
            if (xfer_p0 && (x_rd_p0 != '0) && !busy_q[x_rd_p0]) err_q <= 1'b1;
        end
    end

    // ---- stage p1: registered register-file write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            rd_p1  <= '0;
            d_p1   <= '0;
        end else if (xfer_p0 && (x_rd_p0 != '0)) begin
            vld_p1 <= 1'b1;
            rd_p1  <= x_rd_p0;
            d_p1   <= x_data_p0;
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = grant_mem;
    assign bus.we_reg    = vld_p1;
    assign bus.rd        = rd_p1;
    assign bus.d         = d_p1;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Testbench for rf_wb_scoreboard: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_rf_wb_scoreboard;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int AW         = 5;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic rst;

    rf_wb_scoreboard_if #(.XLEN(XLEN), .NREG(NREG)) bus();

    rf_wb_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit          m_busy [NREG];
    int          m_losses;
    bit          m_we;
    int          m_rd;
    logic [31:0] m_d;
    bit          m_err;
    bit          regs_known = 1'b0;
    bit          g_a, g_m;

    task automatic step(input bit r, input bit iv, input int rs1, input int rs2, input int ird,
                        input bit av, input int ard, input logic [31:0] adat,
                        input bit mv, input int mrd, input logic [31:0] mdat,
                        output bit ga, output bit gm);
        bit contested, hz, es, xfer;
        int xrd;
        logic [31:0] xdat;
        logic [NREG-1:0] bv;
        bit nb [NREG];
        @(negedge clk);
        rst             = r;
        bus.issue_valid = iv;
        bus.issue_rs1   = rs1[AW-1:0];
        bus.issue_rs2   = rs2[AW-1:0];
        bus.issue_rd    = ird[AW-1:0];
        bus.alu_valid   = av;
        bus.alu_rd      = ard[AW-1:0];
        bus.alu_data    = adat;
        bus.mem_valid   = mv;
        bus.mem_rd      = mrd[AW-1:0];
        bus.mem_data    = mdat;
        #1;
        contested = av && mv;
        ga = 1'b0;
        gm = 1'b0;
        if (!r) begin
            if (contested) begin
                if (m_losses >= STARVE_MAX) ga = 1'b1;
                else                        gm = 1'b1;
            end else begin
                ga = av;
                gm = mv;
            end
        end
        hz = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]) || (ird != 0 && m_busy[ird]);
        es = !r && iv && hz;
        chk("stall", 32'(bus.stall), 32'(es));
        chk("alu_ready", 32'(bus.alu_ready), 32'(ga));
        chk("mem_ready", 32'(bus.mem_ready), 32'(gm));
        if (regs_known) begin
            for (int i = 0; i < NREG; i++) bv[i] = m_busy[i];
            chk("we_reg", 32'(bus.we_reg), 32'(m_we));
            chk("rd", 32'(bus.rd), 32'(m_rd));
            chk("d", bus.d, m_d);
            chk("busy", bus.busy, bv);
            chk("err", 32'(bus.err), 32'(m_err));
        end
        if (r) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            m_losses   = 0;
            m_we       = 1'b0;
            m_rd       = 0;
            m_d        = '0;
            m_err      = 1'b0;
            regs_known = 1'b1;
        end else begin
            nb = m_busy;
            if (iv && !es && ird != 0) nb[ird] = 1'b1;
            if (m_we) nb[m_rd] = 1'b0;
            xfer = ga || gm;
            xrd  = ga ? ard : mrd;
            xdat = ga ? adat : mdat;
            if (xfer && xrd != 0 && !m_busy[xrd]) m_err = 1'b1;
            if (xfer && xrd != 0) begin
                m_we = 1'b1;
                m_rd = xrd;
                m_d  = xdat;
            end else begin
                m_we = 1'b0;
            end
            if (contested && gm) m_losses = (m_losses < STARVE_MAX) ? m_losses + 1 : STARVE_MAX;
            else                 m_losses = 0;
            m_busy = nb;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, g_a, g_m);
    endtask

    task automatic issue(input int rs1, input int rs2, input int ird);
        step(0, 1, rs1, rs2, ird, 0, 0, 32'h0, 0, 0, 32'h0, g_a, g_m);
    endtask

    // Prefer busy destinations so most random writebacks are legitimate
    function automatic int pick_rd();
        int k;
        if ($urandom_range(0, 3) != 0) begin
            for (int t = 0; t < 8; t++) begin
                k = $urandom_range(1, NREG - 1);
                if (m_busy[k]) return k;
            end
        end
        return $urandom_range(0, NREG - 1);
    endfunction

    initial begin
        bit ap, mp, r, iv;
        int ard_r, mrd_r;
        logic [31:0] adr, mdr;

        m_losses = 0;
        m_we = 1'b0;
        m_rd = 0;
        m_d = '0;
        m_err = 1'b0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;

        // Reset with both sources requesting
        step(1, 0, 0, 0, 0, 1, 0, 32'h11, 1, 0, 32'h22, g_a, g_m);
        step(1, 0, 0, 0, 0, 1, 0, 32'h11, 1, 0, 32'h22, g_a, g_m);
        chk("t1_alu_ready_rst", 32'(bus.alu_ready), 32'd0);
        chk("t1_busy_rst", bus.busy, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h11, 1, 0, 32'h22, g_a, g_m);
        chk("t1_mem_first", 32'(bus.mem_ready), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 32'h11, 0, 0, 32'h0, g_a, g_m);
        chk("t1_alu_after", 32'(bus.alu_ready), 32'd1);

        // RAW on x5
        issue(0, 0, 5);
        issue(5, 0, 0);
        chk("t2_stall", 32'(bus.stall), 32'd1);
        issue(5, 0, 0);
        step(0, 1, 5, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0, g_a, g_m);
        chk("t2_alu_xfer", 32'(bus.alu_ready), 32'd1);
        issue(5, 0, 0);
        chk("t2_we", 32'(bus.we_reg), 32'd1);
        chk("t2_rd", 32'(bus.rd), 32'd5);
        chk("t2_d", bus.d, 32'hDEADBEEF);
        chk("t2_stall_we", 32'(bus.stall), 32'd1);
        issue(5, 0, 0);
        chk("t2_busy5", 32'(bus.busy[5]), 32'd0);
        chk("t2_unstall", 32'(bus.stall), 32'd0);

        // Continuous contention: MEM x3 then ALU, repeating
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 32'hA0, 1, 0, 32'(i), g_a, g_m);
            chk("t3_alu_win", 32'(bus.alu_ready), 32'((i % 4) == 3));
            chk("t3_mem_win", 32'(bus.mem_ready), 32'((i % 4) != 3));
        end

        // x0 writes and x0 issue
        step(0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'hCAFE, g_a, g_m);
        chk("t4_mem_ready", 32'(bus.mem_ready), 32'd1);
        idle();
        chk("t4_no_we", 32'(bus.we_reg), 32'd0);
        chk("t4_busy", bus.busy, 32'd0);
        chk("t4_err", 32'(bus.err), 32'd0);

        // WAW on x7, then unexpected write to x9
        issue(0, 0, 7);
        issue(0, 0, 7);
        chk("t5_waw_stall", 32'(bus.stall), 32'd1);
        step(0, 1, 0, 0, 7, 1, 7, 32'h77, 0, 0, 32'h0, g_a, g_m);
        issue(0, 0, 7);
        chk("t5_still_stall", 32'(bus.stall), 32'd1);
        issue(0, 0, 7);
        chk("t5_released", 32'(bus.stall), 32'd0);
        chk("t5_err_clean", 32'(bus.err), 32'd0);
        step(0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 32'h0, g_a, g_m);
        idle();
        chk("t5_err_set", 32'(bus.err), 32'd1);
        idle();
        chk("t5_err_sticky", 32'(bus.err), 32'd1);

        // Mid-operation reset with a pending ALU result and two ALU losses
        issue(0, 0, 3);
        step(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 0, 32'h1, g_a, g_m);
        step(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 0, 32'h2, g_a, g_m);
        chk("t6_busy3", 32'(bus.busy[3]), 32'd1);
        step(1, 0, 0, 0, 0, 1, 3, 32'h33, 1, 0, 32'h3, g_a, g_m);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 32'h44, 1, 0, 32'h5, g_a, g_m);
            if (i == 0) begin
                chk("t6_busy_clr", bus.busy, 32'd0);
                chk("t6_no_write", 32'(bus.we_reg), 32'd0);
                chk("t6_err_clr", 32'(bus.err), 32'd0);
            end
            chk("t6_starve_clr", 32'(bus.alu_ready), 32'(i == 3));
        end

        // Randomized traffic; losing sources hold their results
        ap = 1'b0;
        mp = 1'b0;
        ard_r = 0; mrd_r = 0; adr = '0; mdr = '0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 99) < 2);
            iv = $urandom_range(0, 1) == 1;
            if (!ap && $urandom_range(0, 2) == 0) begin
                ap = 1'b1; ard_r = pick_rd(); adr = $urandom;
            end
            if (!mp && $urandom_range(0, 2) == 0) begin
                mp = 1'b1; mrd_r = pick_rd(); mdr = $urandom;
            end
            step(r, iv, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                 $urandom_range(0, NREG - 1), ap, ard_r, adr, mp, mrd_r, mdr, g_a, g_m);
            if (r) begin
                ap = 1'b0;
                mp = 1'b0;
            end else begin
                if (g_a) ap = 1'b0;
                if (g_m) mp = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
